// File: rtl/bp_profiler_pkg.sv
// bp_profiler_pkg
//   Shared types and constants for the profiler sampler.
//   - bp_profiler_sampler_state_e : burst FSM states (idle, header word, data words)
//   - hdr_magic_abs_gp            : header tag byte when streaming absolute counter values
//   - hdr_magic_delta_gp          : header tag byte when streaming deltas since the last burst
package bp_profiler_pkg;

    typedef enum logic [1:0] {
        e_ps_idle = 2'd0,
        e_ps_hdr  = 2'd1,
        e_ps_data = 2'd2
    } bp_profiler_sampler_state_e;

    localparam logic [7:0] hdr_magic_abs_gp   = 8'hA5;
    localparam logic [7:0] hdr_magic_delta_gp = 8'hD5;

endpackage

// File: rtl/bp_profiler_sample_timer.sv
// bp_profiler_sample_timer
//   Free-running sample-period timer. Counts while enabled with a non-zero period and
//   pulses tick_o on the cycle the count reaches period_i-1, then restarts from 0.
//   Comparing with >= means lowering period_i below the current count ticks at once.
// Ports
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   en_i       timer enable
//   period_i   cycles between ticks; 0 disables the timer
//   tick_o     one-cycle sample request
module bp_profiler_sample_timer #(
    parameter int unsigned period_width_p = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      en_i,
    input  logic [period_width_p-1:0] period_i,
    output logic                      tick_o
);

    logic [period_width_p-1:0] count_r;
    logic                      run;

    assign run    = en_i & (period_i != '0);
    assign tick_o = run & (count_r >= (period_i - period_width_p'(1)));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else if (!run || tick_o) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + period_width_p'(1);
        end
    end

endmodule

// File: rtl/bp_profiler_sampler.sv
// bp_profiler_sampler
//   Snapshots the profiler counter bank on a periodic tick or a manual trigger and
//   streams it word-serially: one header word {magic, seq} followed by els_p counter
//   words, last_o on the final word. Requests arriving while a burst is held are
//   dropped and counted (saturating) in dropped_o.
//   Build option BP_PROFILER_SAMPLER_DELTA_EN: stream snap[i]-prev[i] instead of the
//   absolute values, with header magic 8'hD5; prev is updated when a burst completes.
// Ports
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   en_i         periodic timer enable
//   period_i     cycles between periodic samples (0 = off)
//   trigger_i    one-cycle manual snapshot request
//   counters_i   live counter bank, word i at [i*width_p +: width_p]
//   data_o       stream word
//   v_o          stream valid
//   ready_and_i  host accepts data_o when v_o & ready_and_i
//   last_o       final word of a burst
//   busy_o       snapshot held / burst in progress
//   dropped_o    saturating count of dropped requests
module bp_profiler_sampler
    import bp_profiler_pkg::*;
#(
    parameter int unsigned width_p        = 32,
    parameter int unsigned els_p          = 56,
    parameter int unsigned period_width_p = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       en_i,
    input  logic [period_width_p-1:0]  period_i,
    input  logic                       trigger_i,
    input  logic [els_p*width_p-1:0]   counters_i,
    output logic [width_p-1:0]         data_o,
    output logic                       v_o,
    input  logic                       ready_and_i,
    output logic                       last_o,
    output logic                       busy_o,
    output logic [width_p-1:0]         dropped_o
);

    localparam int unsigned seq_width_lp = width_p - 8;
    localparam int unsigned idx_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

    bp_profiler_sampler_state_e state_r;
    logic [idx_width_lp-1:0]    idx_r;
    logic [seq_width_lp-1:0]    seq_r;
    logic [width_p-1:0]         dropped_r;
    logic [width_p-1:0]         snap_r [els_p];
    logic [width_p-1:0]         word;
    logic                       tick;
    logic                       req;
    logic                       is_last;

    bp_profiler_sample_timer #(
        .period_width_p(period_width_p)
    ) timer (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .en_i     (en_i),
        .period_i (period_i),
        .tick_o   (tick)
    );

    assign req     = tick | trigger_i;
    assign busy_o  = (state_r != e_ps_idle);
    assign is_last = (state_r == e_ps_data) && (idx_r == idx_width_lp'(els_p - 1));
    assign last_o  = is_last;
    assign dropped_o = dropped_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_ps_idle;
            idx_r   <= '0;
            seq_r   <= '0;
        end else begin
            case (state_r)
                e_ps_idle: if (req) state_r <= e_ps_hdr;
                e_ps_hdr: begin
                    if (ready_and_i) begin
                        state_r <= e_ps_data;
                        idx_r   <= '0;
                    end
                end
                e_ps_data: begin
                    if (ready_and_i) begin
                        if (is_last) begin
                            state_r <= e_ps_idle;
                            seq_r   <= seq_r + seq_width_lp'(1);
                        end else begin
                            idx_r <= idx_r + idx_width_lp'(1);
                        end
                    end
                end
                default: state_r <= e_ps_idle;
            endcase
        end
    end

    // Request while busy (including the final-accept cycle) is lost, never queued.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dropped_r <= '0;
        end else if (req && busy_o && (dropped_r != '1)) begin
            dropped_r <= dropped_r + width_p'(1);
        end
    end

    // Snapshot is only captured from idle, so it cannot change mid-burst.
    always_ff @(posedge clk_i) begin
        if ((state_r == e_ps_idle) && req) begin
            for (int unsigned i = 0; i < els_p; i++) begin
                snap_r[i] <= counters_i[i*width_p +: width_p];
            end
        end
    end

`ifdef BP_PROFILER_SAMPLER_DELTA_EN
    localparam logic [7:0] hdr_magic_lp = hdr_magic_delta_gp;

    logic [width_p-1:0] prev_r [els_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < els_p; i++) begin
                prev_r[i] <= '0;
            end
        end else if (is_last && ready_and_i) begin
            for (int unsigned i = 0; i < els_p; i++) begin
                prev_r[i] <= snap_r[i];
            end
        end
    end

    assign word = snap_r[idx_r] - prev_r[idx_r];
`else
    localparam logic [7:0] hdr_magic_lp = hdr_magic_abs_gp;

    assign word = snap_r[idx_r];
`endif

    always_comb begin
        v_o    = 1'b0;
        data_o = '0;
        case (state_r)
            e_ps_hdr: begin
                v_o    = 1'b1;
                data_o = {hdr_magic_lp, seq_r};
            end
            e_ps_data: begin
                v_o    = 1'b1;
                data_o = word;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bp_profiler_sampler.sv
// Self-checking bench for bp_profiler_sampler. A transaction-level model (a queue of
// pending stream words) predicts v_o/busy_o/data_o/last_o/dropped_o every cycle; a
// small second instance (width 16, 4 counters) exercises the header sequence wrap.
module tb_bp_profiler_sampler;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 56;
    localparam int unsigned PW = 32;
`ifdef BP_PROFILER_SAMPLER_DELTA_EN
    localparam logic [7:0] MAGIC = 8'hD5;
`else
    localparam logic [7:0] MAGIC = 8'hA5;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          trigger = 1'b0;
    logic          ready = 1'b0;
    logic [PW-1:0] period = '0;
    logic [N*W-1:0] counters = '0;
    logic [W-1:0]  data;
    logic [W-1:0]  dropped;
    logic          v, last, busy;

    logic          s_trig = 1'b0;
    logic [15:0]   s_data, s_dropped;
    logic          s_v, s_last, s_busy;

    always #5 clk = ~clk;

    bp_profiler_sampler #(.width_p(W), .els_p(N), .period_width_p(PW)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .period_i(period),
        .trigger_i(trigger), .counters_i(counters), .data_o(data), .v_o(v),
        .ready_and_i(ready), .last_o(last), .busy_o(busy), .dropped_o(dropped)
    );

    bp_profiler_sampler #(.width_p(16), .els_p(4), .period_width_p(8)) dut_small (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(1'b0), .period_i(8'd0),
        .trigger_i(s_trig), .counters_i(64'h0004_0003_0002_0001), .data_o(s_data),
        .v_o(s_v), .ready_and_i(1'b1), .last_o(s_last), .busy_o(s_busy),
        .dropped_o(s_dropped)
    );

    // ---------------- model ----------------
    logic [W-1:0] q[$];
    logic [W-1:0] m_burst [N];
    logic [W-1:0] m_prev  [N];
    logic [23:0]  m_seq;
    logic [W-1:0] m_dropped;
    longint       m_timer;
    int           errors = 0;
    int           checks = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_seq     = '0;
        m_dropped = '0;
        m_timer   = 0;
        for (int i = 0; i < N; i++) m_prev[i] = '0;
    endtask

    task automatic model_step();
        logic tick;
        logic was_busy;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick = 1'b0;
        if (en && period != '0) begin
            if (m_timer >= longint'(period) - 1) begin
                tick = 1'b1;
                m_timer = 0;
            end else begin
                m_timer++;
            end
        end else begin
            m_timer = 0;
        end
        was_busy = (q.size() != 0);
        if (tick || trigger) begin
            if (was_busy) begin
                if (m_dropped != '1) m_dropped++;
            end else begin
                q.push_back({MAGIC, m_seq});
                for (int i = 0; i < N; i++) begin
                    m_burst[i] = counters[i*W +: W];
`ifdef BP_PROFILER_SAMPLER_DELTA_EN
                    q.push_back(m_burst[i] - m_prev[i]);
`else
                    q.push_back(m_burst[i]);
`endif
                end
            end
        end
        if (was_busy && ready) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                m_seq++;
                m_prev = m_burst;
            end
        end
    endtask

    task automatic compare();
        check("v_o", W'(v), W'(q.size() != 0));
        check("busy_o", W'(busy), W'(q.size() != 0));
        check("dropped_o", dropped, m_dropped);
        if (q.size() != 0) begin
            check("data_o", data, q[0]);
            check("last_o", W'(last), W'(q.size() == 1));
        end else begin
            check("last_o_idle", W'(last), '0);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic drain(output int lasts);
        int n;
        n = 0;
        lasts = 0;
        while ((busy || v) && n < 1000) begin
            if (v && ready && last) lasts++;
            cyc();
            n++;
        end
        check("drain_busy", W'(busy), '0);
    endtask

    int n, acc, lasts;
    logic [W-1:0] exp_w0;

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) counters[i*W +: W] = W'(i);

        // reset state
        cyc();
        cyc();
        check("rst_v", W'(v), '0);
        check("rst_last", W'(last), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_data", data, '0);
        check("rst_dropped", dropped, '0);
        rst_n = 1'b1;
        cyc();

        // 1: periodic sampling
        ready = 1'b1;
        period = 32'd10;
        en = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!v && n < 200);
        check("t1_latency", W'(n), 32'd10);
        check("t1_hdr0", data, {MAGIC, 24'h000000});
        n = 0;
        while (busy && n < 200) begin cyc(); n++; end
        n = 0;
        while (!v && n < 200) begin cyc(); n++; end
        check("t1_hdr1", data, {MAGIC, 24'h000001});
        en = 1'b0;
        drain(lasts);

        // 2: manual trigger with stalling host
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        acc = 0;
        n = 0;
        while (acc < 57 && n < 400) begin
            ready = ~ready;
            if (v && ready) acc++;
            cyc();
            n++;
        end
        check("t2_accepts", W'(acc), 32'd57);
        check("t2_busy_after", W'(busy), '0);
        ready = 1'b1;

        // 3: trigger every cycle for 100 cycles
        do_reset();
        trigger = 1'b1;
        repeat (100) cyc();
        trigger = 1'b0;
        check("t3_dropped", dropped, 32'd98);
        drain(lasts);

        // 4: tick and trigger on the same edge
        do_reset();
        period = 32'd3;
        en = 1'b1;
        cyc();
        cyc();
        check("t4_no_early", W'(v), '0);
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        en = 1'b0;
        check("t4_hdr", data, {MAGIC, 24'h000000});
        drain(lasts);
        check("t4_bursts", W'(lasts), 32'd1);
        check("t4_dropped", dropped, '0);

        // 5: asynchronous reset mid-DATA (idx = 20)
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        repeat (21) cyc();
        #2 rst_n = 1'b0;
        #1;
        check("t5_v_async", W'(v), '0);
        check("t5_busy_async", W'(busy), '0);
        model_reset();
        cyc();
        rst_n = 1'b1;
        cyc();
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        check("t5_hdr_seq0", data, {MAGIC, 24'h000000});
        drain(lasts);

        // 6: counters advance by 3 between bursts, word 0 wraps
        for (int i = 0; i < N; i++) counters[i*W +: W] = W'(100 + i);
        counters[0 +: W] = 32'hFFFF_FFFE;
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        drain(lasts);
        for (int i = 0; i < N; i++) counters[i*W +: W] = counters[i*W +: W] + 32'd3;
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        check("t6_hdr_byte", W'(data[31:24]), W'(MAGIC));
        cyc();
`ifdef BP_PROFILER_SAMPLER_DELTA_EN
        exp_w0 = 32'd3;
`else
        exp_w0 = 32'd1;
`endif
        check("t6_word0", data, exp_w0);
        drain(lasts);

        // sequence wrap on the narrow instance (8-bit seq)
        for (int k = 0; k < 257; k++) begin
            s_trig = 1'b1;
            cyc();
            s_trig = 1'b0;
            check("seq_hdr", W'(s_data), W'({MAGIC, 8'(k)}));
            repeat (5) cyc();
        end
        check("seq_busy_end", W'(s_busy), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
